// File: rtl/chacha_stream_ctrl.sv
// Sequencer for a combinational ChaCha20 block core: builds the 512-bit input
// state, waits CORE_LAT cycles for the core to settle, and streams keystream blocks.
module chacha_stream_ctrl #(
  parameter int CORE_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  ctr_init,
  input  logic [15:0]  num_blocks,
  output logic [511:0] core_state_in,
  input  logic [511:0] core_state_out,
  output logic [511:0] ks_data,
  output logic         ks_valid,
  input  logic         ks_ready,
  output logic         ks_last,
  output logic         busy,
  output logic         done,
  output logic         err_wrap
);

  localparam logic [127:0] SIGMA = {32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};
  localparam logic [3:0]   LAT   = 4'(CORE_LAT);

  typedef enum logic [1:0] {IDLE, SETTLE, OUT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_q;
  logic [31:0] ctr_q;
  logic [15:0] rem_q;

  logic accept, load, capture, reload, finish, wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and synthesis never has to infer a latch to hold it.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    load    = 1'b0;
    capture = 1'b0;
    reload  = 1'b0;
    finish  = 1'b0;
    wrap    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          accept = 1'b1;
          if (num_blocks != 16'd0) begin
            load    = 1'b1;
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (wait_q == 4'd1) begin
          capture = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (ks_ready) begin
          if (rem_q == 16'd1) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else if (ctr_q == 32'hFFFF_FFFF) begin
            // Incrementing would silently reuse counter 0, so stop and flag it.
            wrap    = 1'b1;
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            reload  = 1'b1;
            state_d = SETTLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_state_in <= '0;
      ks_data       <= '0;
      ks_valid      <= 1'b0;
      done          <= 1'b0;
      err_wrap      <= 1'b0;
      wait_q        <= '0;
      ctr_q         <= '0;
      rem_q         <= '0;
    end else begin
      done     <= finish | (accept & (num_blocks == 16'd0));
      ks_valid <= (state_d == OUT);

      if (accept) begin
        err_wrap <= 1'b0;
        ctr_q    <= ctr_init;
        rem_q    <= num_blocks;
      end
      if (wrap) err_wrap <= 1'b1;

      if (load) begin
        core_state_in <= {SIGMA, key, ctr_init, nonce};
        wait_q        <= LAT;
      end else if (reload) begin
        // Only word 12 changes between blocks of a job.
        core_state_in[127:96] <= ctr_q + 32'd1;
        ctr_q                 <= ctr_q + 32'd1;
        rem_q                 <= rem_q - 16'd1;
        wait_q                <= LAT;
      end else if (state_q == SETTLE) begin
        wait_q <= wait_q - 4'd1;
      end

      if (capture) ks_data <= core_state_out;
    end
  end

  assign busy    = (state_q != IDLE);
  assign ks_last = ks_valid & (rem_q == 16'd1);

endmodule

// File: tb/tb_chacha_stream_ctrl.sv
// Bench for chacha_stream_ctrl: a behavioural ChaCha20 core with settle delay,
// directed jobs, and a scoreboard checked by an independent handshake monitor.
module tb_chacha_stream_ctrl;

  localparam int CORE_LAT = 2;
  localparam logic [127:0] SIGMA = {32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};
  localparam logic [255:0] KEY_RFC = {32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                                      32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c};
  localparam logic [95:0]  NONCE_RFC = {32'h09000000, 32'h4a000000, 32'h00000000};
  localparam logic [255:0] KEY_B   = {8{32'h5a5a_1234}};
  localparam logic [95:0]  NONCE_B = {32'hcafe_0001, 32'hcafe_0002, 32'hcafe_0003};
  localparam logic [255:0] KEY_C   = {8{32'h0f0f_a5a5}};
  localparam logic [95:0]  NONCE_C = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [255:0] key = '0;
  logic [95:0]  nonce = '0;
  logic [31:0]  ctr_init = '0;
  logic [15:0]  num_blocks = '0;
  logic [511:0] core_state_in;
  logic [511:0] core_state_out;
  logic [511:0] ks_data;
  logic         ks_valid;
  logic         ks_ready = 1'b0;
  logic         ks_last;
  logic         busy;
  logic         done;
  logic         err_wrap;

  chacha_stream_ctrl #(.CORE_LAT(CORE_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .key(key), .nonce(nonce),
    .ctr_init(ctr_init), .num_blocks(num_blocks), .core_state_in(core_state_in),
    .core_state_out(core_state_out), .ks_data(ks_data), .ks_valid(ks_valid),
    .ks_ready(ks_ready), .ks_last(ks_last), .busy(busy), .done(done), .err_wrap(err_wrap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] qr(input logic [31:0] a_i, b_i, c_i, d_i);
    logic [31:0] a, b, c, d;
    a = a_i; b = b_i; c = c_i; d = d_i;
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] chacha_block(input logic [511:0] s);
    logic [31:0]  x [16];
    logic [31:0]  o [16];
    logic [511:0] r;
    for (int i = 0; i < 16; i++) begin
      x[i] = s[511-32*i -: 32];
      o[i] = x[i];
    end
    for (int rnd = 0; rnd < 10; rnd++) begin
      {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
    end
    for (int i = 0; i < 16; i++) r[511-32*i -: 32] = x[i] + o[i];
    return r;
  endfunction

  function automatic logic [511:0] build(input logic [255:0] k, input logic [31:0] c,
                                         input logic [95:0] n);
    return {SIGMA, k, c, n};
  endfunction

  // Core model: output is garbage until the input has been stable long enough.
  logic [511:0] core_prev = '0;
  int           core_age = 0;
  always @(negedge clk) begin
    if (core_state_in !== core_prev) begin
      core_prev = core_state_in;
      core_age  = 0;
    end else if (core_age < 100) begin
      core_age++;
    end
  end
  assign core_state_out = (core_age >= CORE_LAT - 1) ? chacha_block(core_prev)
                                                     : {16{32'hbad0_0bad}};

  typedef struct {
    logic [511:0] data;
    logic         last;
    logic [31:0]  ctr;
  } exp_t;
  exp_t sb[$];

  task automatic push_job(input logic [255:0] k, input logic [95:0] n,
                          input logic [31:0] c0, input int nb);
    logic [31:0] c;
    exp_t e;
    c = c0;
    for (int i = 0; i < nb; i++) begin
      e.data = chacha_block(build(k, c, n));
      e.last = (i == nb - 1);
      e.ctr  = c;
      sb.push_back(e);
      if (c == 32'hFFFF_FFFF) break;
      c = c + 32'd1;
    end
  endtask

  // Monitor: sampled mid-cycle, so valid & ready & !abort means a handshake next edge.
  logic [511:0] hold_data;
  logic         hold_last;
  logic         hold_valid = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ks_valid) begin
      if (hold_valid) begin
        check("ks_data stable", ks_data, hold_data);
        check("ks_last stable", 512'(ks_last), 512'(hold_last));
      end
      hold_valid = 1'b1;
      hold_data  = ks_data;
      hold_last  = ks_last;
      if (ks_ready && !abort) begin
        hold_valid = 1'b0;
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected block: got ctr %0h expected no block", core_state_in[127:96]);
        end else begin
          e = sb.pop_front();
          check("ks_data", ks_data, e.data);
          check("ks_last", 512'(ks_last), 512'(e.last));
          check("word12 ctr", 512'(core_state_in[127:96]), 512'(e.ctr));
        end
      end
    end else begin
      hold_valid = 1'b0;
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [255:0] k, input logic [95:0] n,
                           input logic [31:0] c, input logic [15:0] nb);
    key = k; nonce = n; ctr_init = c; num_blocks = nb;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!ks_valid && n < 20) begin
      tick();
      n++;
    end
    check("ks_valid arrives", 512'(ks_valid), 512'(1));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    check("job ends", 512'(busy), 512'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int d0;

    // Reset state
    #12;
    check("reset ks_valid", 512'(ks_valid), 512'(0));
    check("reset busy", 512'(busy), 512'(0));
    check("reset done", 512'(done), 512'(0));
    check("reset err_wrap", 512'(err_wrap), 512'(0));
    check("reset ks_last", 512'(ks_last), 512'(0));
    check("reset ks_data", ks_data, '0);
    check("reset core_state_in", core_state_in, '0);
    @(posedge clk); #3 rst = 1'b0;
    tick();

    // RFC 8439 block, ready held high
    ks_ready = 1'b1;
    push_job(KEY_RFC, NONCE_RFC, 32'd1, 1);
    start_job(KEY_RFC, NONCE_RFC, 32'd1, 16'd1);
    check("t1 busy", 512'(busy), 512'(1));
    check("t1 core_state_in", core_state_in, build(KEY_RFC, 32'd1, NONCE_RFC));
    check("t1 valid k", 512'(ks_valid), 512'(0));
    tick();
    check("t1 valid k+1", 512'(ks_valid), 512'(0));
    tick();
    check("t1 valid k+2", 512'(ks_valid), 512'(1));
    check("t1 ks_last", 512'(ks_last), 512'(1));
    check("t1 word0", 512'(ks_data[511:480]), 512'(32'he4e7f110));
    tick();
    check("t1 done", 512'(done), 512'(1));
    check("t1 busy after", 512'(busy), 512'(0));
    check("t1 valid after", 512'(ks_valid), 512'(0));
    tick();
    check("t1 done pulse", 512'(done), 512'(0));

    // Backpressure, three blocks from counter 5
    ks_ready = 1'b0;
    d0 = done_cnt;
    push_job(KEY_B, NONCE_B, 32'd5, 3);
    start_job(KEY_B, NONCE_B, 32'd5, 16'd3);
    for (int b = 0; b < 3; b++) begin
      wait_valid();
      repeat (4) tick();
      ks_ready = 1'b1;
      tick();
      ks_ready = 1'b0;
    end
    check("t2 done", 512'(done), 512'(1));
    wait_idle();
    tick();
    check("t2 done count", 512'(done_cnt - d0), 512'(1));

    // Counter wrap
    ks_ready = 1'b1;
    d0 = done_cnt;
    push_job(KEY_B, NONCE_B, 32'hFFFF_FFFE, 4);
    start_job(KEY_B, NONCE_B, 32'hFFFF_FFFE, 16'd4);
    check("t3 err_wrap cleared", 512'(err_wrap), 512'(0));
    wait_idle();
    check("t3 done", 512'(done), 512'(1));
    check("t3 err_wrap", 512'(err_wrap), 512'(1));
    tick();
    check("t3 done count", 512'(done_cnt - d0), 512'(1));
    check("t3 blocks consumed", 512'(sb.size()), 512'(0));

    // num_blocks = 0, also clears err_wrap
    start_job(KEY_C, NONCE_C, 32'd77, 16'd0);
    check("t4 done", 512'(done), 512'(1));
    check("t4 busy", 512'(busy), 512'(0));
    check("t4 err_wrap", 512'(err_wrap), 512'(0));
    check("t4 core_state_in held", core_state_in, build(KEY_B, 32'hFFFF_FFFF, NONCE_B));
    tick();
    check("t4 done pulse", 512'(done), 512'(0));
    check("t4 valid", 512'(ks_valid), 512'(0));

    // Abort during SETTLE
    d0 = done_cnt;
    start_job(KEY_C, NONCE_C, 32'd9, 16'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5 busy", 512'(busy), 512'(0));
    check("t5 valid", 512'(ks_valid), 512'(0));
    check("t5 done", 512'(done), 512'(0));
    repeat (3) tick();
    check("t5 done count", 512'(done_cnt - d0), 512'(0));

    // Abort coincident with handshake and start
    ks_ready = 1'b0;
    d0 = done_cnt;
    start_job(KEY_C, NONCE_C, 32'd10, 16'd2);
    wait_valid();
    ks_ready = 1'b1; abort = 1'b1; start = 1'b1;
    tick();
    check("t6 busy", 512'(busy), 512'(0));
    check("t6 valid", 512'(ks_valid), 512'(0));
    check("t6 done", 512'(done), 512'(0));
    tick();
    check("t6 start blocked", 512'(busy), 512'(0));
    abort = 1'b0; start = 1'b0; ks_ready = 1'b0;
    repeat (2) tick();
    check("t6 done count", 512'(done_cnt - d0), 512'(0));

    // Asynchronous reset mid-OUT, then a clean job
    start_job(KEY_RFC, NONCE_RFC, 32'd1, 16'd1);
    wait_valid();
    rst = 1'b1;
    #2;
    check("t7 valid async", 512'(ks_valid), 512'(0));
    check("t7 busy async", 512'(busy), 512'(0));
    check("t7 ks_data async", ks_data, '0);
    @(posedge clk); #3 rst = 1'b0;
    tick();
    ks_ready = 1'b1;
    d0 = done_cnt;
    push_job(KEY_RFC, NONCE_RFC, 32'd1, 1);
    start_job(KEY_RFC, NONCE_RFC, 32'd1, 16'd1);
    wait_idle();
    tick();
    check("t7 done count", 512'(done_cnt - d0), 512'(1));

    repeat (3) tick();
    check("scoreboard drained", 512'(sb.size()), 512'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
